fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter LINE_BITS, default 8: local-store line address width (128-byte lines, 256 lines = 32 KB).
REQ-002 Parameter START_LINE, default 0: line fetched first after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode cannot accept an instruction pair this cycle.
REQ-006 branch_taken  input  1  redirect request, valid only while issue_valid=1.
REQ-007 branch_target  input  [0:LINE_BITS+4]  target word address {line, slot}; slot = low 5 bits.
REQ-008 ls_ack  input  1  local store has the requested 1024-bit line on inst_set this cycle.
REQ-009 ls_req  output  1  line request to local store.
REQ-010 ls_addr  output  [0:LINE_BITS-1]  requested/current line address.
REQ-011 inst_number  output  [0:4]  slot index driven to the instruction line buffer.
REQ-012 fetch_reset  output  1  forces the line buffer outputs to zero.
REQ-013 issue_valid  output  1  line buffer outputs are a valid pair this cycle.
REQ-014 pc  output  [0:LINE_BITS+4]  {ls_addr, inst_number}, word address of instruction1.

Function
REQ-015 The FSM SHALL have two states: FETCH and RUN.
REQ-016 In FETCH: ls_req=1, fetch_reset=1, issue_valid=0; ls_addr and inst_number SHALL be held stable until ls_ack is sampled high.
REQ-017 ls_ack sampled high in FETCH SHALL move to RUN on that edge; the first valid pair appears the following cycle (one-cycle line latency).
REQ-018 ls_ack while ls_req=0 SHALL be ignored.
REQ-019 In RUN: ls_req=0, fetch_reset=0, issue_valid=1.
REQ-020 RUN with stall=1 and branch_taken=0 SHALL hold all state and outputs.
REQ-021 RUN with stall=0, no branch: odd inst_number 1..29 -> +1; even inst_number 0..28 -> +2 (dual issue to the next even slot).
REQ-022 RUN with stall=0, no branch, inst_number 30 or 31: go to FETCH, ls_addr=ls_addr+1 modulo 2^LINE_BITS (255 wraps to 0), inst_number=0.
REQ-023 branch_taken SHALL take priority over stall; it is sampled only in RUN and ignored in FETCH.
REQ-024 Branch to a different line (or any branch when the same-line feature is compiled out): go to FETCH, ls_addr=target line, inst_number=target slot.
REQ-025 Entry at an odd slot SHALL be legal; the line buffer returns that slot plus NOP, then REQ-021 applies.
REQ-026 pc SHALL equal {ls_addr, inst_number} combinationally in every state.

Reset
REQ-027 While reset=0: state=FETCH, ls_addr=START_LINE, inst_number=0, ls_req=0, fetch_reset=1, issue_valid=0.
REQ-028 ls_req SHALL rise on the first rising edge after reset deasserts; the reset value of ls_req is 0 only.
REQ-029 Reset asserted mid-FETCH SHALL drop ls_req immediately (asynchronously); any pending ack is discarded.

Configuration
REQ-030 Macro FETCH_SAME_LINE_BR_EN defined: a branch whose target line equals ls_addr SHALL stay in RUN with inst_number=target slot on the next edge (no fetch, no bubble beyond the branch cycle).
REQ-031 Macro FETCH_SAME_LINE_BR_EN undefined: every taken branch SHALL follow REQ-024.

Verification
REQ-032 Reset release, ack 3 cycles after ls_req -> ls_addr=0, first pair valid at slot 0, then slots 2,4,...,30 on consecutive unstalled cycles, then FETCH of line 1.
REQ-033 Stall held 4 cycles at slot 6 -> inst_number stays 6, issue_valid stays 1, advances to 8 when stall drops.
REQ-034 Branch to {line 5, slot 17} from line 2 -> FETCH line 5, then slots 17, 18, 20, ...
REQ-035 Line 255 slot 30, stall=0 -> ls_addr=0, inst_number=0, FETCH.
REQ-036 Branch to same line slot 9 together with stall=1 -> with macro: RUN, inst_number=9 next cycle; without macro: FETCH of same line.
REQ-037 Reset pulsed low while ls_req=1 and ack arrives same cycle -> ack ignored, outputs return to reset values, fresh FETCH of START_LINE.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller <-> decode / local-store bundle.
// master: the fetch controller; slave: decode + local store side.
interface fetch_ctrl_if #(
    parameter int LINE_BITS = 8
);
    logic                 stall;
    logic                 branch_taken;
    logic [0:LINE_BITS+4] branch_target;
    logic                 ls_ack;
    logic                 ls_req;
    logic [0:LINE_BITS-1] ls_addr;
    logic [0:4]           inst_number;
    logic                 fetch_reset;
    logic                 issue_valid;
    logic [0:LINE_BITS+4] pc;

    modport master (
        input  stall, branch_taken, branch_target, ls_ack,
        output ls_req, ls_addr, inst_number, fetch_reset, issue_valid, pc
    );

    modport slave (
        output stall, branch_taken, branch_target, ls_ack,
        input  ls_req, ls_addr, inst_number, fetch_reset, issue_valid, pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests 1024-bit lines from the local store
// and walks the slot index through the line buffer, dual-issuing even pairs.
// Optional macro FETCH_SAME_LINE_BR_EN: a taken branch into the current line
// only rewrites the slot index instead of refetching the line.
module fetch_ctrl #(
    parameter int LINE_BITS  = 8,
    parameter int START_LINE = 0
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic [4:0]           slot_q, slot_d;
    logic                 ls_req_q;

    logic [LINE_BITS+4:0] tgt;
    logic [LINE_BITS-1:0] tgt_line;
    logic [4:0]           tgt_slot;

    assign tgt      = bus.branch_target;
    assign tgt_line = tgt[LINE_BITS+4:5];
    assign tgt_slot = tgt[4:0];

    // Next-state: wait for the line in FETCH; in RUN, branch beats stall beats advance.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        slot_d  = slot_q;
        if (state_q == ST_FETCH) begin
            // an ack is only meaningful once the request is actually on the bus
            if (ls_req_q && bus.ls_ack)
                state_d = ST_RUN;
        end else if (bus.branch_taken) begin
`ifdef FETCH_SAME_LINE_BR_EN
            if (tgt_line == line_q) begin
                slot_d = tgt_slot;
            end else begin
                state_d = ST_FETCH;
                line_d  = tgt_line;
                slot_d  = tgt_slot;
            end
`else
            state_d = ST_FETCH;
            line_d  = tgt_line;
            slot_d  = tgt_slot;
`endif
        end else if (!bus.stall) begin
            if (slot_q >= 5'd30) begin
                state_d = ST_FETCH;
                line_d  = line_q + LINE_BITS'(1);
                slot_d  = 5'd0;
            end else if (slot_q[0]) begin
                // odd entry issues one instruction plus NOP, realigning to even
                slot_d = slot_q + 5'd1;
            end else begin
                slot_d = slot_q + 5'd2;
            end
        end
    end

    // State registers; ls_req is registered so it resets low and rises one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            line_q   <= LINE_BITS'(START_LINE);
            slot_q   <= 5'd0;
            ls_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            slot_q   <= slot_d;
            ls_req_q <= (state_d == ST_FETCH);
        end
    end

    assign bus.ls_req      = ls_req_q;
    assign bus.ls_addr     = line_q;
    assign bus.inst_number = slot_q;
    assign bus.fetch_reset = (state_q == ST_FETCH);
    assign bus.issue_valid = (state_q == ST_RUN);
    assign bus.pc          = {line_q, slot_q};
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, line walk, stall, branches,
// line wrap, same-line branch and reset during a pending fetch.
module tb_fetch_ctrl;
    localparam int LB = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fetch_ctrl_if #(.LINE_BITS(LB)) bus ();

    fetch_ctrl #(.LINE_BITS(LB), .START_LINE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LB+4:0] tgt(input int line, input int slot);
        return (LB+5)'(line * 32 + slot);
    endfunction

    // req, fetch_reset, issue_valid, line, slot, and pc derived from line/slot
    task automatic chk_st(input string tag, input logic req, input logic frst,
                          input logic iv, input int line, input int slot);
        chk({tag, ".ls_req"},      bus.ls_req,      req);
        chk({tag, ".fetch_reset"}, bus.fetch_reset, frst);
        chk({tag, ".issue_valid"}, bus.issue_valid, iv);
        chk({tag, ".ls_addr"},     bus.ls_addr,     line);
        chk({tag, ".inst_number"}, bus.inst_number, slot);
        chk({tag, ".pc"},          bus.pc,          line * 32 + slot);
    endtask

    // present ack for one edge; the pair is valid right after that edge
    task automatic ack_line();
        bus.ls_ack = 1'b1;
        step();
        bus.ls_ack = 1'b0;
    endtask

    initial begin
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.ls_ack        = 1'b0;
        #1;
        chk_st("rst0", 0, 1, 0, 0, 0);
        step();
        step();
        chk_st("rst_hold", 0, 1, 0, 0, 0);

        // release with a stray ack while ls_req is still low: must be ignored
        reset      = 1'b1;
        bus.ls_ack = 1'b1;
        step();
        bus.ls_ack = 1'b0;
        chk_st("req_rise", 1, 1, 0, 0, 0);
        step();
        step();
        chk_st("fetch_wait", 1, 1, 0, 0, 0);
        ack_line();
        chk_st("run0", 0, 0, 1, 0, 0);
        for (int s = 2; s <= 30; s += 2) begin
            step();
            chk("walk.slot", bus.inst_number, s);
            chk("walk.iv", bus.issue_valid, 1);
        end
        step();
        chk_st("next_line", 1, 1, 0, 1, 0);

        // stall held at slot 6
        ack_line();
        step();
        step();
        step();
        chk_st("pre_stall", 0, 0, 1, 1, 6);
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_st("stall", 0, 0, 1, 1, 6);
        end
        bus.stall = 1'b0;
        step();
        chk_st("unstall", 0, 0, 1, 1, 8);

        // branch to line 2 slot 3; branch during FETCH is ignored
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt(2, 3);
        step();
        chk_st("br_l2", 1, 1, 0, 2, 3);
        bus.branch_target = tgt(7, 0);
        step();
        bus.branch_taken = 1'b0;
        chk_st("br_in_fetch", 1, 1, 0, 2, 3);
        ack_line();
        chk_st("odd_entry", 0, 0, 1, 2, 3);
        step();
        chk_st("odd_next", 0, 0, 1, 2, 4);

        // branch from line 2 to line 5 slot 17
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt(5, 17);
        step();
        bus.branch_taken = 1'b0;
        chk_st("br_l5", 1, 1, 0, 5, 17);
        ack_line();
        chk_st("l5_17", 0, 0, 1, 5, 17);
        step();
        chk_st("l5_18", 0, 0, 1, 5, 18);
        step();
        chk_st("l5_20", 0, 0, 1, 5, 20);

        // same-line branch to slot 9 while stalled
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt(5, 9);
        step();
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
`ifdef FETCH_SAME_LINE_BR_EN
        chk_st("same_line", 0, 0, 1, 5, 9);
`else
        chk_st("same_line", 1, 1, 0, 5, 9);
        ack_line();
        chk_st("same_line_run", 0, 0, 1, 5, 9);
`endif
        step();
        chk_st("same_line_nxt", 0, 0, 1, 5, 10);

        // line 255 wraps to 0
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt(255, 29);
        step();
        bus.branch_taken = 1'b0;
        chk_st("br_l255", 1, 1, 0, 255, 29);
        ack_line();
        step();
        chk_st("l255_30", 0, 0, 1, 255, 30);
        step();
        chk_st("wrap", 1, 1, 0, 0, 0);

        // reset during a pending fetch with an ack in the same cycle
        ack_line();
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt(9, 4);
        step();
        bus.branch_taken = 1'b0;
        chk_st("br_l9", 1, 1, 0, 9, 4);
        bus.ls_ack = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_st("async_rst", 0, 1, 0, 0, 0);
        step();
        bus.ls_ack = 1'b0;
        chk_st("rst_ack_ign", 0, 1, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_st("refetch", 1, 1, 0, 0, 0);
        ack_line();
        chk_st("refetch_run", 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
